// File: rtl/saw_seq_pkg.sv
// Shared types and default sizing for the sawtooth note sequencer.
package saw_seq_pkg;

    localparam int unsigned DEPTH_DEF       = 16;
    localparam int unsigned TF_W_DEF        = 24;
    localparam int unsigned DUR_W_DEF       = 16;
    localparam int unsigned GAP_SAMPLES_DEF = 480;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_PLAY,
        S_GAP,
        S_DONE
    } seq_state_e;

    typedef struct packed {
        logic [TF_W_DEF-1:0]  tf;
        logic [DUR_W_DEF-1:0] dur;
    } note_t;

endpackage

// File: rtl/saw_note_table.sv
// Note table: DEPTH entries of {tone word, duration}, one write port, one async read port.
module saw_note_table
    import saw_seq_pkg::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEF,
    parameter int unsigned TF_W  = TF_W_DEF,
    parameter int unsigned DUR_W = DUR_W_DEF,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en_i,
    input  logic [AW-1:0]    wr_addr_i,
    input  logic [TF_W-1:0]  wr_tf_i,
    input  logic [DUR_W-1:0] wr_dur_i,
    input  logic [AW-1:0]    rd_addr_i,
    output logic [TF_W-1:0]  rd_tf_c,
    output logic [DUR_W-1:0] rd_dur_c
);

    logic [TF_W-1:0]  tf_q  [DEPTH];
    logic [DUR_W-1:0] dur_q [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                tf_q[i]  <= '0;
                dur_q[i] <= '0;
            end
        end else if (wr_en_i) begin
            tf_q[wr_addr_i]  <= wr_tf_i;
            dur_q[wr_addr_i] <= wr_dur_i;
        end
    end

    // Reading the pre-write contents gives old-value semantics on a same-cycle write.
    assign rd_tf_c  = tf_q[rd_addr_i];
    assign rd_dur_c = dur_q[rd_addr_i];

endmodule

// File: rtl/saw_note_seq.sv
// Steps the saw generator through the note table, timing notes and gaps in output samples.
module saw_note_seq
    import saw_seq_pkg::*;
#(
    parameter int unsigned DEPTH       = DEPTH_DEF,
    parameter int unsigned TF_W        = TF_W_DEF,
    parameter int unsigned DUR_W       = DUR_W_DEF,
    parameter int unsigned GAP_SAMPLES = GAP_SAMPLES_DEF,
    localparam int unsigned AW         = $clog2(DEPTH)
) (
    input  logic             i_clk48,
    input  logic             i_rst48_n,
    input  logic             i_sample_pulse,
    input  logic             i_start,
    input  logic             i_stop,
    input  logic             i_loop,
    input  logic             i_wr_en,
    input  logic [AW-1:0]    i_wr_addr,
    input  logic [TF_W-1:0]  i_wr_tf,
    input  logic [DUR_W-1:0] i_wr_dur,
    output logic [TF_W-1:0]  o_tf,
    output logic             o_pause,
    output logic             o_busy,
    output logic [AW-1:0]    o_note_idx,
    output logic             o_done
);

    localparam int unsigned GW = (GAP_SAMPLES > 0) ? $clog2(GAP_SAMPLES + 1) : 1;

    seq_state_e        state_q, state_d;
    logic [AW-1:0]     idx_q, idx_d;
    logic [DUR_W-1:0]  cnt_q, cnt_d;
    logic [GW-1:0]     gcnt_q, gcnt_d;
    logic [TF_W-1:0]   tf_q, tf_d;
    logic              pause_q, pause_d;
    logic              busy_q, busy_d;
    logic [AW-1:0]     note_idx_q, note_idx_d;
    logic              done_q, done_d;
    logic [TF_W-1:0]   rd_tf;
    logic [DUR_W-1:0]  rd_dur;
    logic              advance;
    logic              end_of_table;

    saw_note_table #(
        .DEPTH (DEPTH),
        .TF_W  (TF_W),
        .DUR_W (DUR_W)
    ) u_table (
        .clk       (i_clk48),
        .rst_n     (i_rst48_n),
        .wr_en_i   (i_wr_en),
        .wr_addr_i (i_wr_addr),
        .wr_tf_i   (i_wr_tf),
        .wr_dur_i  (i_wr_dur),
        .rd_addr_i (idx_q),
        .rd_tf_c   (rd_tf),
        .rd_dur_c  (rd_dur)
    );

    always_ff @(posedge i_clk48 or negedge i_rst48_n) begin
        if (!i_rst48_n) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            cnt_q      <= '0;
            gcnt_q     <= '0;
            tf_q       <= '0;
            pause_q    <= 1'b1;
            busy_q     <= 1'b0;
            note_idx_q <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            gcnt_q     <= gcnt_d;
            tf_q       <= tf_d;
            pause_q    <= pause_d;
            busy_q     <= busy_d;
            note_idx_q <= note_idx_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        cnt_d        = cnt_q;
        gcnt_d       = gcnt_q;
        tf_d         = tf_q;
        pause_d      = pause_q;
        note_idx_d   = note_idx_q;
        advance      = 1'b0;
        end_of_table = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                pause_d = 1'b1;
                if (i_start && !i_stop) begin
                    state_d = S_LOAD;
                    idx_d   = '0;
                end
            end
            S_LOAD: begin
                if (rd_dur == '0) begin
                    // An empty first entry means an empty program: finish without looping.
                    if (idx_q == '0) state_d = S_DONE;
                    else             end_of_table = 1'b1;
                end else begin
                    tf_d       = rd_tf;
                    cnt_d      = rd_dur;
                    pause_d    = 1'b0;
                    note_idx_d = idx_q;
                    state_d    = S_PLAY;
                end
            end
            S_PLAY: begin
                if (i_sample_pulse) begin
                    cnt_d = cnt_q - DUR_W'(1);
                    if (cnt_q == DUR_W'(1)) begin
                        pause_d = 1'b1;
                        if (GAP_SAMPLES > 0) begin
                            state_d = S_GAP;
                            gcnt_d  = GW'(GAP_SAMPLES);
                        end else begin
                            advance = 1'b1;
                        end
                    end
                end
            end
            S_GAP: begin
                if (i_sample_pulse) begin
                    gcnt_d = gcnt_q - GW'(1);
                    if (gcnt_q == GW'(1)) advance = 1'b1;
                end
            end
            S_DONE: begin
                pause_d = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (advance) begin
            if (idx_q == AW'(DEPTH - 1)) begin
                end_of_table = 1'b1;
            end else begin
                idx_d   = idx_q + AW'(1);
                state_d = S_LOAD;
            end
        end

        if (end_of_table) begin
            if (i_loop) begin
                idx_d   = '0;
                state_d = S_LOAD;
            end else begin
                state_d = S_DONE;
            end
        end

        // Stop wins over every other transition and never reports completion.
        if (i_stop && state_q != S_IDLE) begin
            state_d = S_IDLE;
            pause_d = 1'b1;
        end
    end

    assign busy_d = (state_d != S_IDLE);
    assign done_d = (state_d == S_DONE);

    assign o_tf       = tf_q;
    assign o_pause    = pause_q;
    assign o_busy     = busy_q;
    assign o_note_idx = note_idx_q;
    assign o_done     = done_q;

endmodule
